// File: rtl/glip_cypressfx2_fx2model_pkg.sv
// Shared definitions for the FX2 slave-FIFO behavioural model.
//   FX2_ADDR_EP2 / FX2_ADDR_EP6 : fifoadr codes that select the two endpoints
//   FX2_WIDTH                   : width of the FX2 data bus
//   ep6_entry_t                 : one EP6 FIFO entry, packet-end marker in the MSB
package glip_cypressfx2_fx2model_pkg;

    localparam logic [1:0] FX2_ADDR_EP2 = 2'b00;
    localparam logic [1:0] FX2_ADDR_EP6 = 2'b10;
    localparam int         FX2_WIDTH    = 16;

    // last must stay the MSB: the FIFO's mark port sets bit WIDTH-1.
    typedef struct packed {
        logic                 last;
        logic [FX2_WIDTH-1:0] data;
    } ep6_entry_t;

endpackage

// File: rtl/glip_fx2model_fifo.sv
// Synchronous FIFO used for both FX2 endpoints.
//   clk, rst_n        : clock, asynchronous active-low reset (pointers only)
//   push, push_data   : write request; accepted when not full, or when a pop
//                       happens in the same cycle
//   pop, head         : read request (ignored when empty), current head word
//   mark_en, mark_ptr : set the MSB of the entry at mark_ptr
//   full, empty       : occupancy flags
//   count             : occupancy in words
//   wr_ptr            : write pointer (log2(DEPTH)+1 bits, MSB is the wrap bit)
module glip_fx2model_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    input  logic                     mark_en,
    input  logic [$clog2(DEPTH)-1:0] mark_ptr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   wr_ptr
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
        if (mark_en) mem[mark_ptr][WIDTH-1] <= 1'b1;
    end

endmodule

// File: rtl/glip_cypressfx2_fx2model.sv
// Behavioural model of the Cypress FX2 in slave-FIFO mode.
//   clk, rst_n            : IFCLK domain, asynchronous active-low reset
//   fx2_fd_in/out, _oe    : FX2 data bus (EP6 writes in, EP2 reads out)
//   fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n, fx2_fifoadr : strobes
//   fx2_flaga_n..flagd_n  : EP2 empty, EP6 full, EP2 full, EP6 empty (active low)
//   host_in_*             : host stream into EP2
//   host_out_*            : host stream out of EP6, last marks a packet end
//   zlp_count             : zero-length packets committed on EP6 (wraps)
//   err_underrun/overrun  : sticky error flags
//
// Host streams: a beat transfers on a rising edge where valid && ready are both
// high; valid never depends on ready. host_out_valid is simply "EP6 not empty".
module glip_cypressfx2_fx2model
    import glip_cypressfx2_fx2model_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FX2_WIDTH-1:0] fx2_fd_in,
    output logic [FX2_WIDTH-1:0] fx2_fd_out,
    output logic                 fx2_fd_oe,
    input  logic                 fx2_sloe_n,
    input  logic                 fx2_slrd_n,
    input  logic                 fx2_slwr_n,
    input  logic                 fx2_pktend_n,
    input  logic [1:0]           fx2_fifoadr,
    output logic                 fx2_flaga_n,
    output logic                 fx2_flagb_n,
    output logic                 fx2_flagc_n,
    output logic                 fx2_flagd_n,
    input  logic [FX2_WIDTH-1:0] host_in_data,
    input  logic                 host_in_valid,
    output logic                 host_in_ready,
    output logic [FX2_WIDTH-1:0] host_out_data,
    output logic                 host_out_last,
    output logic                 host_out_valid,
    input  logic                 host_out_ready,
    output logic [7:0]           zlp_count,
    output logic                 err_underrun,
    output logic                 err_overrun
);

    localparam int AW = $clog2(DEPTH);

    // Reset asserts asynchronously and releases two edges after rst_n rises.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic                 ep2_sel, ep6_sel;
    logic                 ep2_push, ep2_pop, ep2_full, ep2_empty;
    logic [FX2_WIDTH-1:0] ep2_head;
    logic [AW:0]          ep2_count, ep2_wr_ptr;
    logic                 ep6_push, ep6_pop, ep6_full, ep6_empty, ep6_wr_try;
    ep6_entry_t           ep6_wdata, ep6_head;
    logic [AW:0]          ep6_count, ep6_wr_ptr, ep6_last_ptr;
    logic                 pktend_alone, mark_en, zlp_inc;
    logic                 underrun_evt, overrun_evt;
    logic                 unused_ep2_ptr;

    assign ep2_sel = (fx2_fifoadr == FX2_ADDR_EP2);
    assign ep6_sel = (fx2_fifoadr == FX2_ADDR_EP6);

    // EP2: host -> FPGA
    assign ep2_pop       = !fx2_slrd_n && !fx2_sloe_n && ep2_sel && !ep2_empty;
    // Ready stays high on a full EP2 while the FPGA pops it, so the pair of
    // transfers in that cycle keeps occupancy at DEPTH.
    assign host_in_ready = !ep2_full || ep2_pop;
    assign ep2_push      = host_in_valid && host_in_ready;
    assign underrun_evt  = !fx2_slrd_n && ep2_sel && (ep2_count == '0);

    glip_fx2model_fifo #(.WIDTH(FX2_WIDTH), .DEPTH(DEPTH)) u_ep2 (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (ep2_push),
        .push_data (host_in_data),
        .pop       (ep2_pop),
        .head      (ep2_head),
        .mark_en   (1'b0),
        .mark_ptr  ('0),
        .full      (ep2_full),
        .empty     (ep2_empty),
        .count     (ep2_count),
        .wr_ptr    (ep2_wr_ptr)
    );
    assign unused_ep2_ptr = ^ep2_wr_ptr;

    assign fx2_fd_oe   = !fx2_sloe_n;
    assign fx2_fd_out  = (!fx2_sloe_n && ep2_sel) ? ep2_head : '0;
    assign fx2_flaga_n = !ep2_empty;
    assign fx2_flagc_n = !ep2_full;

    // EP6: FPGA -> host
    assign ep6_pop        = host_out_valid && host_out_ready;
    assign ep6_wr_try     = !fx2_slwr_n && ep6_sel;
    assign ep6_push       = ep6_wr_try && (!ep6_full || ep6_pop);
    assign overrun_evt    = ep6_wr_try && ep6_full && !ep6_pop;
    assign ep6_wdata.last = !fx2_pktend_n;
    assign ep6_wdata.data = fx2_fd_in;

    // A lone pktend closes the packet on the newest word if it has not been
    // drained yet; with nothing buffered it commits a zero-length packet.
    assign pktend_alone = !fx2_pktend_n && ep6_sel && fx2_slwr_n;
    assign ep6_last_ptr = ep6_wr_ptr - {{AW{1'b0}}, 1'b1};
    assign mark_en      = pktend_alone && (ep6_count != '0);
    assign zlp_inc      = pktend_alone && ep6_empty;

    glip_fx2model_fifo #(.WIDTH($bits(ep6_entry_t)), .DEPTH(DEPTH)) u_ep6 (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (ep6_push),
        .push_data (ep6_wdata),
        .pop       (ep6_pop),
        .head      (ep6_head),
        .mark_en   (mark_en),
        .mark_ptr  (ep6_last_ptr[AW-1:0]),
        .full      (ep6_full),
        .empty     (ep6_empty),
        .count     (ep6_count),
        .wr_ptr    (ep6_wr_ptr)
    );

    assign fx2_flagb_n    = !ep6_full;
    assign fx2_flagd_n    = !ep6_empty;
    assign host_out_valid = !ep6_empty;
    // Gate the unreset storage so the host side reads zero when nothing is buffered.
    assign host_out_data  = ep6_empty ? '0 : ep6_head.data;
    assign host_out_last  = !ep6_empty && ep6_head.last;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            zlp_count    <= 8'd0;
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (zlp_inc)      zlp_count    <= zlp_count + 8'd1;
            if (underrun_evt) err_underrun <= 1'b1;
            if (overrun_evt)  err_overrun  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glip_cypressfx2_fx2model.sv
module tb_glip_cypressfx2_fx2model;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] fx2_fd_in;
    logic [15:0] fx2_fd_out;
    logic        fx2_fd_oe;
    logic        fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n;
    logic [1:0]  fx2_fifoadr;
    logic        fx2_flaga_n, fx2_flagb_n, fx2_flagc_n, fx2_flagd_n;
    logic [15:0] host_in_data;
    logic        host_in_valid, host_in_ready;
    logic [15:0] host_out_data;
    logic        host_out_last, host_out_valid, host_out_ready;
    logic [7:0]  zlp_count;
    logic        err_underrun, err_overrun;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [15:0] exp_ep2_q[$];
    logic [16:0] exp_ep6_q[$];

    glip_cypressfx2_fx2model #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fx2_fd_in      (fx2_fd_in),
        .fx2_fd_out     (fx2_fd_out),
        .fx2_fd_oe      (fx2_fd_oe),
        .fx2_sloe_n     (fx2_sloe_n),
        .fx2_slrd_n     (fx2_slrd_n),
        .fx2_slwr_n     (fx2_slwr_n),
        .fx2_pktend_n   (fx2_pktend_n),
        .fx2_fifoadr    (fx2_fifoadr),
        .fx2_flaga_n    (fx2_flaga_n),
        .fx2_flagb_n    (fx2_flagb_n),
        .fx2_flagc_n    (fx2_flagc_n),
        .fx2_flagd_n    (fx2_flagd_n),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_last  (host_out_last),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .zlp_count      (zlp_count),
        .err_underrun   (err_underrun),
        .err_overrun    (err_overrun)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every word the DUT hands out against the expected queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!fx2_slrd_n && !fx2_sloe_n && fx2_fifoadr == 2'b00 && fx2_flaga_n) begin
                if (exp_ep2_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL ep2_unexpected: got %0h expected no word", fx2_fd_out);
                end else begin
                    check("ep2_fd_out", {16'h0, fx2_fd_out}, {16'h0, exp_ep2_q.pop_front()});
                end
            end
            if (host_out_valid && host_out_ready) begin
                if (exp_ep6_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL ep6_unexpected: got %0h expected no word", {host_out_last, host_out_data});
                end else begin
                    check("ep6_host_out", {15'h0, host_out_last, host_out_data}, {15'h0, exp_ep6_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fx2_idle();
        fx2_sloe_n   = 1'b1;
        fx2_slrd_n   = 1'b1;
        fx2_slwr_n   = 1'b1;
        fx2_pktend_n = 1'b1;
        fx2_fifoadr  = 2'b01;
    endtask

    task automatic host_push(input logic [15:0] d);
        host_in_valid = 1'b1;
        host_in_data  = d;
        exp_ep2_q.push_back(d);
        tick();
        host_in_valid = 1'b0;
    endtask

    task automatic fx2_read(input int n);
        fx2_fifoadr = 2'b00;
        fx2_sloe_n  = 1'b0;
        fx2_slrd_n  = 1'b0;
        repeat (n) tick();
        fx2_idle();
    endtask

    // accept: whether the bench expects EP6 to take the word
    task automatic fx2_write(input logic [15:0] d, input logic pktend, input logic accept);
        fx2_fifoadr  = 2'b10;
        fx2_slwr_n   = 1'b0;
        fx2_fd_in    = d;
        fx2_pktend_n = !pktend;
        if (accept) exp_ep6_q.push_back({pktend, d});
        tick();
        fx2_idle();
    endtask

    // Lone pktend: closes the newest buffered word, or expects a ZLP.
    task automatic fx2_pktend_alone();
        logic [16:0] tmp;
        fx2_fifoadr  = 2'b10;
        fx2_pktend_n = 1'b0;
        if (exp_ep6_q.size() != 0) begin
            tmp = exp_ep6_q.pop_back();
            tmp[16] = 1'b1;
            exp_ep6_q.push_back(tmp);
        end
        tick();
        fx2_idle();
    endtask

    task automatic host_drain(input int budget);
        int n;
        n = 0;
        host_out_ready = 1'b1;
        while (host_out_valid && n < budget) begin
            tick();
            n++;
        end
        if (host_out_valid) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain_timeout: host_out_valid still 1 after %0d cycles, required 0", budget);
        end
        host_out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fx2_idle();
        fx2_fd_in      = 16'h0;
        host_in_data   = 16'h0;
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        rst_n          = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_fd_out", {16'h0, fx2_fd_out}, 32'h0);
        check("rst_fd_oe", {31'h0, fx2_fd_oe}, 32'h0);
        check("rst_flaga_n", {31'h0, fx2_flaga_n}, 32'h0);
        check("rst_flagb_n", {31'h0, fx2_flagb_n}, 32'h1);
        check("rst_flagc_n", {31'h0, fx2_flagc_n}, 32'h1);
        check("rst_flagd_n", {31'h0, fx2_flagd_n}, 32'h0);
        check("rst_host_in_ready", {31'h0, host_in_ready}, 32'h1);
        check("rst_host_out_valid", {31'h0, host_out_valid}, 32'h0);
        check("rst_host_out_last", {31'h0, host_out_last}, 32'h0);
        check("rst_zlp_count", {24'h0, zlp_count}, 32'h0);
        check("rst_err_underrun", {31'h0, err_underrun}, 32'h0);
        check("rst_err_overrun", {31'h0, err_overrun}, 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Unused endpoint address: no write, no error
        fx2_fifoadr = 2'b01;
        fx2_slwr_n  = 1'b0;
        fx2_fd_in   = 16'h5555;
        tick();
        fx2_idle();
        check("adr01_flagd_n", {31'h0, fx2_flagd_n}, 32'h0);
        check("adr01_err_overrun", {31'h0, err_overrun}, 32'h0);

        // Host -> FPGA
        for (int i = 1; i <= 4; i++) host_push(i[15:0]);
        check("h2f_flaga_n_filled", {31'h0, fx2_flaga_n}, 32'h1);
        fx2_sloe_n  = 1'b0;
        fx2_fifoadr = 2'b10;
        #1;
        check("fd_out_other_ep", {16'h0, fx2_fd_out}, 32'h0);
        check("fd_oe_driven", {31'h0, fx2_fd_oe}, 32'h1);
        fx2_read(4);
        check("h2f_flaga_n_drained", {31'h0, fx2_flaga_n}, 32'h0);

        // FPGA -> host with pktend, then a ZLP
        for (int i = 0; i < 3; i++) fx2_write(16'hA000 + i[15:0], 1'b0, 1'b1);
        fx2_pktend_alone();
        check("f2h_head_data", {16'h0, host_out_data}, 32'hA000);
        check("f2h_head_last", {31'h0, host_out_last}, 32'h0);
        host_drain(10);
        fx2_pktend_alone();
        check("f2h_zlp_count", {24'h0, zlp_count}, 32'h1);

        // EP6 full and overrun
        for (int i = 0; i < DEPTH; i++) fx2_write(16'hB000 + i[15:0], 1'b0, 1'b1);
        check("full_flagb_n", {31'h0, fx2_flagb_n}, 32'h0);
        check("full_err_overrun_before", {31'h0, err_overrun}, 32'h0);
        fx2_write(16'hBFFF, 1'b0, 1'b0);
        check("full_err_overrun", {31'h0, err_overrun}, 32'h1);
        check("full_head_word0", {16'h0, host_out_data}, 32'hB000);
        host_drain(DEPTH + 4);
        check("full_flagb_n_after_drain", {31'h0, fx2_flagb_n}, 32'h1);

        // EP2 underrun
        fx2_fifoadr = 2'b00;
        fx2_slrd_n  = 1'b0;
        tick();
        fx2_idle();
        check("underrun_err", {31'h0, err_underrun}, 32'h1);
        check("underrun_flaga_n", {31'h0, fx2_flaga_n}, 32'h0);

        // EP2 full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) host_push(16'hC000 + i[15:0]);
        check("simul_flagc_n_full", {31'h0, fx2_flagc_n}, 32'h0);
        check("simul_ready_full", {31'h0, host_in_ready}, 32'h0);
        fx2_fifoadr   = 2'b00;
        fx2_sloe_n    = 1'b0;
        fx2_slrd_n    = 1'b0;
        host_in_valid = 1'b1;
        host_in_data  = 16'hCF00;
        #1;
        check("simul_ready_with_pop", {31'h0, host_in_ready}, 32'h1);
        exp_ep2_q.push_back(16'hCF00);
        tick();
        host_in_valid = 1'b0;
        fx2_idle();
        check("simul_still_full", {31'h0, fx2_flagc_n}, 32'h0);
        fx2_read(DEPTH);
        check("simul_flaga_n_drained", {31'h0, fx2_flaga_n}, 32'h0);

        // Reset mid-packet
        fx2_write(16'hD000, 1'b0, 1'b1);
        fx2_write(16'hD001, 1'b0, 1'b1);
        check("midrst_valid_before", {31'h0, host_out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_now", {31'h0, host_out_valid}, 32'h0);
        check("midrst_flagd_n", {31'h0, fx2_flagd_n}, 32'h0);
        check("midrst_err_cleared", {30'h0, err_underrun, err_overrun}, 32'h0);
        check("midrst_zlp_cleared", {24'h0, zlp_count}, 32'h0);
        exp_ep6_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        fx2_write(16'hD002, 1'b1, 1'b1);
        check("midrst_new_word", {15'h0, host_out_last, host_out_data}, 32'h1D002);
        host_drain(4);

        // Everything expected was seen
        check("ep2_queue_empty", exp_ep2_q.size(), 32'h0);
        check("ep6_queue_empty", exp_ep6_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
